// File: rtl/bch_dec_synd_seq.sv
// Sequential DEC BCH syndrome generator.
// Folds a captured codeword into S1 = c(alpha) and S3 = c(alpha^3) by Horner
// iteration, P_BITS_PER_CLK bits per clock, MSB first. The result is presented
// with the pass-through data on a valid/ready output.
module bch_dec_synd_seq #(
    parameter  int P_D_WIDTH      = 16,
    parameter  int P_BITS_PER_CLK = 1,
    // Smallest field order m in 5..8 with 2^m-1 >= P_D_WIDTH+2m
    localparam int M = (P_D_WIDTH + 10 <= 31)  ? 5 :
                       (P_D_WIDTH + 12 <= 63)  ? 6 :
                       (P_D_WIDTH + 14 <= 127) ? 7 : 8,
    localparam int N = P_D_WIDTH + 2 * M
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 abort_i,
    input  logic                 in_vld_i,
    output logic                 in_rdy_o,
    input  logic [P_D_WIDTH-1:0] data_i,
    input  logic [2*M-1:0]       ecc_i,
    output logic                 out_vld_o,
    input  logic                 out_rdy_i,
    output logic [2*M-1:0]       syndromes_o,
    output logic [P_D_WIDTH-1:0] data_o,
    output logic                 err_det_o
);

    localparam int CNT_W = $clog2(N + 1);

    // Primitive polynomial low terms (x^m term implicit), alpha = x
    localparam logic [7:0] POLY_ALL = (M == 5) ? 8'h05 :
                                      (M == 6) ? 8'h03 :
                                      (M == 7) ? 8'h09 : 8'h1D;
    localparam logic [M-1:0] POLY = POLY_ALL[M-1:0];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // A codeword length that does not divide into whole chunks is a config error
    generate
        if (N % P_BITS_PER_CLK != 0) begin : g_bad_cfg
            $error("bch_dec_synd_seq: codeword length not a multiple of P_BITS_PER_CLK");
        end
    endgenerate

    // Multiply by alpha: shift up, reduce the overflowing x^m term
    function automatic logic [M-1:0] mul_a(input logic [M-1:0] x);
        return {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY : '0);
    endfunction

    function automatic logic [M-1:0] mul_a3(input logic [M-1:0] x);
        return mul_a(mul_a(mul_a(x)));
    endfunction

    logic [1:0]           state_q;
    logic [N-1:0]         cw_q;
    logic [P_D_WIDTH-1:0] data_q;
    logic [M-1:0]         s1_q, s3_q;
    logic [M-1:0]         s1_nxt, s3_nxt;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_chunk;
    logic                 accept;

    assign in_rdy_o   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_rdy_i);
    assign accept     = in_vld_i & in_rdy_o;
    assign last_chunk = (cnt_q == CNT_W'(N - P_BITS_PER_CLK));

    // Horner step over the next chunk; the chunk sits at the top of cw_q
    always_comb begin
        s1_nxt = s1_q;
        s3_nxt = s3_q;
        for (int k = 0; k < P_BITS_PER_CLK; k++) begin
            s1_nxt = mul_a(s1_nxt)  ^ {{(M-1){1'b0}}, cw_q[N-1-k]};
            s3_nxt = mul_a3(s3_nxt) ^ {{(M-1){1'b0}}, cw_q[N-1-k]};
        end
    end

    // Control FSM, datapath and registered outputs; abort outranks the handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cw_q        <= '0;
            data_q      <= '0;
            s1_q        <= '0;
            s3_q        <= '0;
            cnt_q       <= '0;
            out_vld_o   <= 1'b0;
            syndromes_o <= '0;
            data_o      <= '0;
            err_det_o   <= 1'b0;
        end else if (abort_i) begin
            state_q   <= S_IDLE;
            out_vld_o <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE && out_rdy_i) begin
                        out_vld_o <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                    if (accept) begin
                        cw_q    <= {data_i, ecc_i};
                        data_q  <= data_i;
                        s1_q    <= '0;
                        s3_q    <= '0;
                        cnt_q   <= '0;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    cw_q  <= cw_q << P_BITS_PER_CLK;
                    s1_q  <= s1_nxt;
                    s3_q  <= s3_nxt;
                    cnt_q <= cnt_q + CNT_W'(P_BITS_PER_CLK);
                    if (last_chunk) begin
                        state_q     <= S_DONE;
                        out_vld_o   <= 1'b1;
                        syndromes_o <= {s3_nxt, s1_nxt};
                        err_det_o   <= |{s3_nxt, s1_nxt};
                        data_o      <= data_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_dec_synd_seq.sv
// Bench for bch_dec_synd_seq: a 1-bit/clk instance (m=5, N=26) for directed
// vectors and corner sequences, and a 2-bit/clk instance for random codewords.
module tb_bch_dec_synd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: P_BITS_PER_CLK = 1
    logic        a_abort, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_err;
    logic [15:0] a_data, a_data_o;
    logic [9:0]  a_ecc, a_synd;

    // Instance B: P_BITS_PER_CLK = 2
    logic        b_abort, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_err;
    logic [15:0] b_data, b_data_o;
    logic [9:0]  b_ecc, b_synd;

    bch_dec_synd_seq #(.P_D_WIDTH(16), .P_BITS_PER_CLK(1)) u_a (
        .clk_i(clk), .rst_i(rst), .abort_i(a_abort),
        .in_vld_i(a_in_vld), .in_rdy_o(a_in_rdy),
        .data_i(a_data), .ecc_i(a_ecc),
        .out_vld_o(a_out_vld), .out_rdy_i(a_out_rdy),
        .syndromes_o(a_synd), .data_o(a_data_o), .err_det_o(a_err)
    );

    bch_dec_synd_seq #(.P_D_WIDTH(16), .P_BITS_PER_CLK(2)) u_b (
        .clk_i(clk), .rst_i(rst), .abort_i(b_abort),
        .in_vld_i(b_in_vld), .in_rdy_o(b_in_rdy),
        .data_i(b_data), .ecc_i(b_ecc),
        .out_vld_o(b_out_vld), .out_rdy_i(b_out_rdy),
        .syndromes_o(b_synd), .data_o(b_data_o), .err_det_o(b_err)
    );

    typedef struct {
        logic [15:0] d;
        logic [9:0]  e;
        logic [9:0]  s;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [9:0]  s;
        logic        err;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    vec_t tbl[6];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // GF(32), x^5+x^2+1: multiply by alpha
    function automatic logic [4:0] gf_ma(input logic [4:0] x);
        return {x[3:0], 1'b0} ^ (x[4] ? 5'h05 : 5'h00);
    endfunction

    // Reference: direct power-sum evaluation, S1 = sum c_i a^i, S3 = sum c_i a^3i
    function automatic logic [9:0] ref_synd(input logic [15:0] d, input logic [9:0] e);
        logic [25:0] cw;
        logic [4:0]  pw [0:30];
        logic [4:0]  s1, s3;
        cw    = {d, e};
        pw[0] = 5'h01;
        for (int i = 1; i < 31; i++) pw[i] = gf_ma(pw[i-1]);
        s1 = '0;
        s3 = '0;
        for (int i = 0; i < 26; i++)
            if (cw[i]) begin
                s1 ^= pw[i % 31];
                s3 ^= pw[(3 * i) % 31];
            end
        return {s3, s1};
    endfunction

    // Present one codeword to A for a single accepting edge (A must be ready)
    task automatic send_a(input logic [15:0] d, input logic [9:0] e,
                          input logic [9:0] s, input logic err, input bit push);
        exp_t x;
        a_data   = d;
        a_ecc    = e;
        a_in_vld = 1'b1;
        @(posedge clk);
        #1;
        a_in_vld = 1'b0;
        if (push) begin
            x.d = d; x.s = s; x.err = err;
            sb_a.push_back(x);
        end
    endtask

    // Wait (bounded) for A's result, check latency and scoreboard entry
    task automatic get_a(input string nm, input int lat);
        int   cyc;
        exp_t x;
        cyc = 0;
        while (!a_out_vld && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_lat"}, cyc, lat);
        if (sb_a.size() == 0) begin
            chk({nm, "_sb_empty"}, 1, 0);
        end else begin
            x = sb_a.pop_front();
            chk({nm, "_synd"}, a_synd,   x.s);
            chk({nm, "_err"},  a_err,    x.err);
            chk({nm, "_data"}, a_data_o, x.d);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] snap;
        int bad;
        exp_t x;
        int cyc;

        // Hand-derived syndromes in GF(32): a^2=04, a^3=08, a^6=0A, a^10=11, a^30=12
        tbl[0] = '{d: 16'h0000, e: 10'h000, s: 10'h000, err: 1'b0};
        tbl[1] = '{d: 16'h0000, e: 10'h001, s: 10'h021, err: 1'b1};
        tbl[2] = '{d: 16'h0000, e: 10'h002, s: 10'h102, err: 1'b1};
        tbl[3] = '{d: 16'h0000, e: 10'h004, s: 10'h144, err: 1'b1};
        tbl[4] = '{d: 16'h0001, e: 10'h000, s: 10'h251, err: 1'b1};
        tbl[5] = '{d: 16'h0001, e: 10'h001, s: 10'h270, err: 1'b1};

        rst = 1'b1;
        a_abort = 0; a_in_vld = 0; a_out_rdy = 1; a_data = '0; a_ecc = '0;
        b_abort = 0; b_in_vld = 0; b_out_rdy = 1; b_data = '0; b_ecc = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_vld", a_out_vld, 0);
        chk("rst_in_rdy",  a_in_rdy,  1);
        chk("rst_synd",    a_synd,    0);
        chk("rst_err",     a_err,     0);
        chk("rst_data",    a_data_o,  0);

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            send_a(tbl[i].d, tbl[i].e, tbl[i].s, tbl[i].err, 1'b1);
            get_a($sformatf("vec%0d", i), 26);
            @(posedge clk);
            #1;
        end

        // Random codewords through the 2-bit/clk instance
        for (int i = 0; i < 6; i++) begin
            b_data   = 16'($urandom);
            b_ecc    = 10'($urandom);
            x.d      = b_data;
            x.s      = ref_synd(b_data, b_ecc);
            x.err    = (x.s != 0);
            sb_b.push_back(x);
            b_in_vld = 1'b1;
            @(posedge clk);
            #1;
            b_in_vld = 1'b0;
            cyc = 0;
            while (!b_out_vld && cyc < 100) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            x = sb_b.pop_front();
            chk($sformatf("rnd%0d_lat", i),  cyc,      13);
            chk($sformatf("rnd%0d_synd", i), b_synd,   x.s);
            chk($sformatf("rnd%0d_err", i),  b_err,    x.err);
            chk($sformatf("rnd%0d_data", i), b_data_o, x.d);
            @(posedge clk);
            #1;
        end

        // Backpressure then back-to-back handover
        a_out_rdy = 1'b0;
        send_a(16'h0001, 10'h000, 10'h251, 1'b1, 1'b1);
        get_a("bp_first", 26);
        snap = a_synd;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (a_synd !== snap || a_out_vld !== 1'b1 || a_in_rdy !== 1'b0) bad++;
        end
        chk("bp_stable", bad, 0);
        a_out_rdy = 1'b1;
        a_data    = 16'h0000;
        a_ecc     = 10'h002;
        a_in_vld  = 1'b1;
        #1;
        chk("b2b_in_rdy", a_in_rdy, 1);
        @(posedge clk);
        #1;
        a_in_vld = 1'b0;
        x.d = 16'h0000; x.s = 10'h102; x.err = 1'b1;
        sb_a.push_back(x);
        chk("b2b_vld_drop", a_out_vld, 0);
        chk("b2b_busy",     a_in_rdy,  0);
        get_a("b2b_second", 26);
        @(posedge clk);
        #1;

        // Abort before the 7th CALC edge
        send_a(16'hBEEF, 10'h155, 10'h000, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_abort = 1'b0;
        chk("abort_out_vld", a_out_vld, 0);
        chk("abort_in_rdy",  a_in_rdy,  1);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (a_out_vld !== 1'b0) bad++;
        end
        chk("abort_no_result", bad, 0);
        send_a(16'h0000, 10'h000, 10'h000, 1'b0, 1'b1);
        get_a("after_abort", 26);
        @(posedge clk);
        #1;

        // Reset while holding a result in DONE
        a_out_rdy = 1'b0;
        send_a(16'h0000, 10'h001, 10'h021, 1'b1, 1'b1);
        get_a("pre_rst", 26);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("done_rst_out_vld", a_out_vld, 0);
        chk("done_rst_synd",    a_synd,    0);
        chk("done_rst_in_rdy",  a_in_rdy,  1);
        chk("done_rst_err",     a_err,     0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
